// File: rtl/lsu_pkg.sv
// Shared types for the MIPS load/store unit: op encoding, sizes, FSM states.
// Helpers normalise illegal op codes and handle sub-word alignment.
package lsu_pkg;

    typedef enum logic [3:0] {
        LB  = 4'b0000,
        LH  = 4'b0001,
        LW  = 4'b0010,
        LBU = 4'b0100,
        LHU = 4'b0101,
        SB  = 4'b1000,
        SH  = 4'b1001,
        SW  = 4'b1010
    } lsu_op_t;

    localparam int STORE_BIT    = 3;
    localparam int UNSIGNED_BIT = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } lsu_state_t;

    // Unknown codes behave as LW.
    function automatic lsu_op_t norm_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b0101, 4'b1000, 4'b1001, 4'b1010:
                norm_op = lsu_op_t'(op);
            default:
                norm_op = LW;
        endcase
    endfunction

    function automatic logic misaligned(input lsu_op_t op,
                                        input logic [31:0] a);
        misaligned = (op[1:0] == SZ_H && a[0]) ||
                     (op[1:0] == SZ_W && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] align_addr(input lsu_op_t op,
                                               input logic [31:0] a);
        align_addr = a;
        if (op[1:0] == SZ_H) align_addr[0] = 1'b0;
        if (op[1:0] == SZ_W) align_addr[1:0] = 2'b00;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
// Purely combinational; the top feeds it the captured word and request.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = word[{off, 3'b000} +: 8];
        lane_h     = word[{off[1], 4'b0000} +: 16];
        load_data  = word;
        merge_word = word;
        case (size)
            SZ_B: begin
                load_data = {{24{lane_b[7] & ~uns}}, lane_b};
                merge_word[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = {{16{lane_h[15] & ~uns}}, lane_h};
                merge_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator with read-modify-write for SB/SH.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses answer resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam logic [2:0] LAST = 3'(READ_LAT - 1);

    lsu_state_t state, state_nx;
    lsu_op_t    op_q, op_in;
    logic [31:0] addr_q, wdata_q, data_q, addr_in;
    logic [31:0] load_data, merge_word, word_idx;
    logic [2:0]  cnt;
    logic        err_q, mis_in, accept, is_store, last;
    logic        unused_addr;

    assign op_in    = norm_op(req_op);
    assign accept   = req_valid && state == S_IDLE;
    assign is_store = op_q[STORE_BIT];
    assign last     = cnt == LAST;
    assign word_idx = {{(32 - IW){1'b0}}, addr_q[IW+1:2]};
    assign unused_addr = ^addr_q[31:IW+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in  = misaligned(op_in, req_addr);
    assign addr_in = req_addr;
`else
    assign mis_in  = 1'b0;
    assign addr_in = align_addr(op_in, req_addr);
`endif

    lsu_lane_align u_align (
        .size       (op_q[1:0]),
        .uns        (op_q[UNSIGNED_BIT]),
        .off        (addr_q[1:0]),
        .word       (data_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req_valid) begin
                if (mis_in)          state_nx = S_RESP;
                else if (op_in == SW) state_nx = S_WR;
                else                 state_nx = S_RD;
            end
            S_RD:   state_nx = S_WAIT;
            S_WAIT: if (last) state_nx = is_store ? S_WR : S_RESP;
            S_WR:   state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= LW;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= op_in;
            addr_q  <= addr_in;
            wdata_q <= req_wdata;
            err_q   <= mis_in;
            cnt     <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 3'd1;
            if (last) data_q <= mem_rdata;
        end
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: req_ready = 1'b1;
            S_RD: begin
                mem_read = 1'b1;
                mem_addr = word_idx;
            end
            S_WR: begin
                mem_write = 1'b1;
                mem_addr  = word_idx;
                mem_wdata = (op_q == SW) ? wdata_q : merge_word;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!is_store && !err_q) resp_rdata = load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed plan cases, random ops vs a
// word-array reference model, and an asynchronous reset during an SH.
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;
    localparam int READ_LAT  = 1;
    localparam int IW = $clog2(MEM_WORDS);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MEM_WORDS), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Data memory with a READ_LAT-deep registered read path.
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] pipe [READ_LAT];
    logic          pre_we = 1'b0;
    logic [IW-1:0] pre_idx = '0;
    logic [31:0]   pre_val = '0;

    assign mem_rdata = pipe[READ_LAT-1];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[mem_addr[IW-1:0]] <= mem_wdata;
        pipe[0] <= mem_read ? mem[mem_addr[IW-1:0]] : 32'h0;
        for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end

    logic [31:0] ref_mem [MEM_WORDS];

    int rd_cyc, wr_cyc, resp_cyc, ready_cyc, n_rd, n_wr, n_resp;
    logic [31:0] rd_addr, wr_addr, wr_data, rdata;
    logic err, both, stray;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata);
        rd_cyc = -1; wr_cyc = -1; resp_cyc = -1; ready_cyc = -1;
        n_rd = 0; n_wr = 0; n_resp = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; rdata = '0;
        err = 1'b0; both = 1'b0; stray = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int c = 1; c <= 20 && ready_cyc < 0; c++) begin
            @(negedge clk);
            if (mem_read) begin
                n_rd++;
                if (rd_cyc < 0) begin rd_cyc = c; rd_addr = mem_addr; end
            end
            if (mem_write) begin
                n_wr++;
                if (wr_cyc < 0) begin
                    wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata;
                end
            end
            if (mem_read && mem_write) both = 1'b1;
            if (!mem_read && !mem_write &&
                (mem_addr != 0 || mem_wdata != 0)) stray = 1'b1;
            if (resp_valid) begin
                n_resp++; resp_cyc = c; rdata = resp_rdata; err = resp_err;
            end
            if (req_ready) ready_cyc = c;
        end
    endtask

    task automatic exec(input logic [3:0] op_raw, input logic [31:0] addr,
                        input logic [31:0] wdata);
        logic [3:0]  op;
        logic [31:0] a, w, v, mask, nw;
        int idx, off, sz, e_rd, e_wr, e_resp, e_ready;
        bit st, un, trap;
        op = op_raw;
        if (!(op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10}))
            op = 4'd2;
        st = op[3]; un = op[2]; sz = int'(op[1:0]);
        a = addr; trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00);
`else
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
`endif
        idx = int'((a >> 2) % MEM_WORDS);
        off = int'(a[1:0]);
        w = ref_mem[idx]; v = '0; nw = w; mask = '0;
        if (trap) begin
            e_rd = -1; e_wr = -1; e_resp = 1; e_ready = 2;
        end else if (!st) begin
            e_rd = 1; e_wr = -1;
            e_resp = 2 + READ_LAT; e_ready = 3 + READ_LAT;
            if (sz == 0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (!un && v[7]) v = v | 32'hFFFF_FF00;
            end else if (sz == 1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (!un && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
        end else if (sz == 2) begin
            e_rd = -1; e_wr = 1; e_resp = 2; e_ready = 3; nw = wdata;
        end else begin
            e_rd = 1; e_wr = 2 + READ_LAT;
            e_resp = 3 + READ_LAT; e_ready = 4 + READ_LAT;
            mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
            nw = (w & ~mask) | ((wdata << (8 * off)) & mask);
        end
        run(op_raw, addr, wdata);
        check("rd_cycle", 32'(rd_cyc), 32'(e_rd));
        check("wr_cycle", 32'(wr_cyc), 32'(e_wr));
        check("resp_cycle", 32'(resp_cyc), 32'(e_resp));
        check("ready_cycle", 32'(ready_cyc), 32'(e_ready));
        check("resp_count", 32'(n_resp), 32'd1);
        check("rd_count", 32'(n_rd), (e_rd > 0) ? 32'd1 : 32'd0);
        check("wr_count", 32'(n_wr), (e_wr > 0) ? 32'd1 : 32'd0);
        check("resp_rdata", rdata, v);
        check("resp_err", 32'(err), 32'(trap));
        check("both_strobes", 32'(both), 32'd0);
        check("idle_bus", 32'(stray), 32'd0);
        if (e_rd > 0) check("rd_addr", rd_addr, 32'(idx));
        if (e_wr > 0) begin
            check("wr_addr", wr_addr, 32'(idx));
            check("wr_data", wr_data, nw);
        end
        if (st && !trap) ref_mem[idx] = nw;
    endtask

    initial begin
        logic [31:0] val;
        bit saw_wr, saw_resp;

        // Preload memory and model while reset is held.
        for (int i = 0; i < MEM_WORDS; i++) begin
            val = (i == 5) ? 32'h8899_AABB :
                  (i == 2) ? 32'h1122_3344 : $urandom;
            @(negedge clk);
            pre_we = 1'b1; pre_idx = IW'(i); pre_val = val;
            ref_mem[i] = val;
        end
        @(negedge clk);
        pre_we = 1'b0;
        check("rst_flags",
              {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write},
              32'b10000);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        exec(4'b0000, 32'h15, 32'h0);
        check("plan_lb", rdata, 32'hFFFF_FFAA);
        check("plan_lb_addr", rd_addr, 32'd5);
        exec(4'b0101, 32'h16, 32'h0);
        check("plan_lhu", rdata, 32'h0000_8899);
        exec(4'b0001, 32'h14, 32'h0);
        check("plan_lh", rdata, 32'hFFFF_AABB);
        exec(4'b1000, 32'h09, 32'hEE);
        check("plan_sb_data", wr_data, 32'h1122_EE44);
        check("plan_sb_cycle", 32'(wr_cyc), 32'(2 + READ_LAT));
        exec(4'b1010, 32'h0C, 32'hDEAD_BEEF);
        check("plan_sw_wr", 32'(wr_cyc), 32'd1);
        check("plan_sw_resp", 32'(resp_cyc), 32'd2);
        exec(4'b0010, 32'h0C, 32'h0);
        check("plan_lw", rdata, 32'hDEAD_BEEF);
        exec(4'b0010, 32'h0E, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("plan_trap_err", 32'(err), 32'd1);
        check("plan_trap_strobes", 32'(n_rd + n_wr), 32'd0);
`else
        check("plan_lw_align", rd_addr, 32'd3);
        check("plan_lw_align_data", rdata, 32'hDEAD_BEEF);
`endif

        // Random ops; addresses fold into 16 words to force reuse.
        for (int i = 0; i < 60; i++)
            exec(4'($urandom), ($urandom & 32'hFFFF_F000) |
                 32'($urandom_range(0, 63)), $urandom);

        // Reset during the WAIT of an SH to word 8.
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b1001;
        req_addr = 32'h22; req_wdata = 32'h0000_5A5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_rd", 32'(mem_read), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_flags",
              {27'd0, req_ready, resp_valid, resp_err, mem_read, mem_write},
              32'b10000);
        check("rst_mid_addr", mem_addr, 32'h0);
        check("rst_mid_wdata", mem_wdata, 32'h0);
        check("rst_mid_rdata", resp_rdata, 32'h0);
        saw_wr = 1'b0; saw_resp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) reset = 1'b1;
            if (mem_write) saw_wr = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
        end
        check("rst_mid_no_write", 32'(saw_wr), 32'd0);
        check("rst_mid_no_resp", 32'(saw_resp), 32'd0);
        check("rst_mid_word", mem[8], ref_mem[8]);
        exec(4'b0010, 32'h20, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage initiator for the MIPS datapath. It accepts one load or store per handshake from execute, supporting byte, halfword and word sizes. It drives the word-addressed data memory's read and write strobes and performs read-modify-write for sub-word stores. It returns aligned, sign- or zero-extended load data to write-back.

## Interface
Parameters:
- MEM_WORDS, 1024: data memory depth in words. Word index width is $clog2(MEM_WORDS).
- READ_LAT, 1: cycles from a mem_read cycle to valid mem_rdata. Range 1 to 4.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; the request is accepted when req_valid && req_ready at a clk edge.
- req_op  in  4  lsu_pkg::lsu_op_t operation.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data. It is 0 for stores and errors.
- resp_err  out  1  misaligned access, valid with resp_valid.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  32  word index: req_addr[31:2], truncated to the index width, with upper bits 0.
- mem_wdata  out  32  word to write.
- mem_rdata  in  32  registered memory read data.

## Operation
- Op encoding:
  - op[3] = store; op[2] = unsigned (loads only); op[1:0] = size (00 byte, 01 half, 10 word).
  - LB=0000, LH=0001, LW=0010, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1010.
  - Any other code is treated as LW.
- Lane mapping is little-endian. The byte lane is addr[1:0], using bits [8*off+7 : 8*off]. The halfword lane is addr[1], using bits [16*addr[1]+15 : 16*addr[1]].
- Request capture:
  - op, addr and wdata are registered on acceptance.
  - The inputs are ignored while req_ready=0.
- State machine: IDLE, RD, WAIT, WR, RESP.
  - IDLE to RD on accept of any load, SB or SH.
  - IDLE to WR on accept of SW.
  - RD always goes to WAIT. It holds mem_read=1 for exactly one cycle.
  - WAIT counts READ_LAT cycles, then captures mem_rdata. A load goes to RESP. SB or SH goes to WR.
  - WR holds mem_write=1 for one cycle, then goes to RESP. The written word is req_wdata for SW, or the captured word with the target lane replaced for SB/SH.
  - RESP holds resp_valid=1 for one cycle, then returns to IDLE.
- mem_read and mem_write are never high together. mem_addr and mem_wdata are 0 whenever both strobes are low.
- Loads: resp_rdata = the selected lane, sign-extended when op[2]=0 and zero-extended when op[2]=1.
- Reset values: req_ready=1, and resp_valid, resp_rdata, resp_err, mem_read, mem_write, mem_addr and mem_wdata all 0. State is IDLE.
- Reset mid-operation:
  - Returns to IDLE immediately and drops all strobes in the same instant.
  - The pending request is lost and no resp_valid is produced.
  - A partially started read-modify-write leaves memory unmodified.

## Timing
- The accept edge ends cycle 0.
- LW/LH/LB with READ_LAT=1:
  - mem_read in cycle 1.
  - Capture at the end of cycle 2.
  - resp_valid in cycle 3.
  - req_ready in cycle 4.
- SW: mem_write in cycle 1, resp_valid in cycle 2, req_ready in cycle 3.
- SB/SH: mem_read in cycle 1, mem_write in cycle 3, resp_valid in cycle 4.
- Each additional READ_LAT cycle adds one cycle to loads and to SB/SH.
- Throughput is one outstanding request. There is no backpressure on the response.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - An access is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]≠0.
  - A misaligned request goes from IDLE directly to RESP with resp_err=1 and resp_rdata=0.
  - No memory strobe is issued, and resp_valid occurs in cycle 1.
- LSU_MISALIGN_TRAP_EN undefined:
  - resp_err is tied 0.
  - Alignment bits are forced to zero: addr[0] for halves, addr[1:0] for words.
  - The access then proceeds normally.

## Structure
- lsu_pkg holds:
  - the lsu_op_t enum and its field-index constants (STORE_BIT=3, UNSIGNED_BIT=2);
  - the size localparams SZ_B, SZ_H, SZ_W;
  - the lsu_state_t enum.
- Sub-module lsu_lane_align is combinational and performs both functions:
  - extract and extend for loads;
  - lane merge for sub-word stores.
- The top level holds the FSM, the request registers and the READ_LAT counter.

## Test plan
- Memory word 5 = 0x8899AABB; LB addr 0x15 -> mem_read in cycle 1 with mem_addr=5; resp_rdata=0xFFFFFFAA in cycle 3.
- Same word; LHU addr 0x16 -> resp_rdata=0x00008899; LH addr 0x14 -> 0xFFFFAABB.
- Word 2 = 0x11223344; SB addr 0x09 with wdata 0xEE -> mem_write in cycle 3 with mem_wdata=0x1122EE44; never both strobes high.
- SW addr 0x0C with wdata 0xDEADBEEF -> mem_write in cycle 1, resp_valid in cycle 2; a following LW returns 0xDEADBEEF.
- LW addr 0x0E:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1 in cycle 1, no strobes;
  - without it: reads word 3.
- Assert reset during the WAIT of an SH -> all outputs 0 asynchronously, no mem_write, and the target word is unchanged after reset release.
